// File: rtl/ahb_apb_fsm_controller_if.sv
// AHB-side request/pipeline signals and APB-side outputs of the AHB-to-APB bridge controller.
// The slave modport is the controller's view; the master modport is the AHB/APB environment's view.
interface ahb_apb_fsm_controller_if;
  logic        valid;
  logic        hwrite;
  logic        hwrite_reg;
  logic [31:0] haddr;
  logic [31:0] haddr1;
  logic [31:0] hwdata;
  logic [2:0]  temp_sel;
  logic [31:0] prdata;

  logic [2:0]  pselx;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        hready_out;
  logic [31:0] hr_data;
  logic [1:0]  hresp;

  modport slave (
    input  valid, hwrite, hwrite_reg, haddr, haddr1, hwdata, temp_sel, prdata,
    output pselx, penable, pwrite, paddr, pwdata, hready_out, hr_data, hresp
  );

  modport master (
    output valid, hwrite, hwrite_reg, haddr, haddr1, hwdata, temp_sel, prdata,
    input  pselx, penable, pwrite, paddr, pwdata, hready_out, hr_data, hresp
  );
endinterface

// File: rtl/ahb_apb_fsm_controller.sv
// AHB-to-APB bridge FSM: every APB transfer is a setup cycle then an access cycle, all outputs registered.
// Reads stall AHB for one cycle (hready_out low in READ); pipelined writes stall it during WRITEP.
module ahb_apb_fsm_controller (
  input  logic                      hclk,
  input  logic                      hreset,
  ahb_apb_fsm_controller_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    RENABLE  = 3'd2,
    WWAIT    = 3'd3,
    WRITE    = 3'd4,
    WRITEP   = 3'd5,
    WENABLE  = 3'd6,
    WENABLEP = 3'd7
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [2:0]  pselx_q,   pselx_d;
  logic        penable_q, penable_d;
  logic        pwrite_q,  pwrite_d;
  logic [31:0] paddr_q,   paddr_d;
  logic [31:0] pwdata_q,  pwdata_d;
  logic        hready_q,  hready_d;

  // State and output registers; reset forces the APB bus idle immediately.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state     <= IDLE;
      pselx_q   <= 3'b000;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= 32'h0;
      pwdata_q  <= 32'h0;
      hready_q  <= 1'b1;
    end else begin
      state     <= next_state;
      pselx_q   <= pselx_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      hready_q  <= hready_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, RENABLE, WENABLE: begin
        if (!bus.valid)      next_state = IDLE;
        else if (bus.hwrite) next_state = WWAIT;
        else                 next_state = READ;
      end
      READ:    next_state = RENABLE;
      WWAIT:   next_state = bus.valid ? WRITEP : WRITE;
      WRITE:   next_state = bus.valid ? WENABLEP : WENABLE;
      WRITEP:  next_state = WENABLEP;
      // A pending write is known from the delayed direction, since its data phase is still in flight.
      WENABLEP: begin
        if (!bus.hwrite_reg) next_state = READ;
        else if (bus.valid)  next_state = WRITEP;
        else                 next_state = WRITE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs are loaded according to the state being entered, so they line up with that state.
  always_comb begin
    pselx_d   = pselx_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    hready_d  = hready_q;
    case (next_state)
      READ: begin
        paddr_d   = bus.haddr;
        pwrite_d  = 1'b0;
        pselx_d   = bus.temp_sel;
        penable_d = 1'b0;
        hready_d  = 1'b0;
      end
      // Write address comes from the delayed copy: data arrives one cycle after its address.
      WRITE, WRITEP: begin
        paddr_d   = bus.haddr1;
        pwdata_d  = bus.hwdata;
        pwrite_d  = 1'b1;
        pselx_d   = bus.temp_sel;
        penable_d = 1'b0;
        hready_d  = (next_state == WRITE);
      end
      RENABLE, WENABLE, WENABLEP: begin
        penable_d = 1'b1;
        hready_d  = 1'b1;
      end
      default: begin
        pselx_d   = 3'b000;
        penable_d = 1'b0;
        hready_d  = 1'b1;
      end
    endcase
  end

  assign bus.pselx      = pselx_q;
  assign bus.penable    = penable_q;
  assign bus.pwrite     = pwrite_q;
  assign bus.paddr      = paddr_q;
  assign bus.pwdata     = pwdata_q;
  assign bus.hready_out = hready_q;
  assign bus.hr_data    = bus.prdata;
  assign bus.hresp      = 2'b00;

  // An access cycle must directly follow a setup cycle to the same slave.
  a_access_after_setup: assert property (
    @(posedge hclk) disable iff (hreset)
      penable_q |-> (!$past(penable_q) && (pselx_q == $past(pselx_q)))
  );

  // AHB is never stalled for more than one cycle at a time.
  a_stall_one_cycle: assert property (
    @(posedge hclk) disable iff (hreset)
      !hready_q |=> hready_q
  );

endmodule

// File: tb/tb_ahb_apb_fsm_controller.sv
// Directed bench for ahb_apb_fsm_controller: per-cycle output vectors and APB transfers are queued
// by the stimulus and popped/compared by an independent monitor one time unit after each rising edge.
module tb_ahb_apb_fsm_controller;

  logic hclk   = 1'b0;
  logic hreset = 1'b0;

  ahb_apb_fsm_controller_if bus ();

  ahb_apb_fsm_controller dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  always #5 hclk = ~hclk;

  // Upstream AHB pipeline registers (address and direction delayed by one cycle).
  always @(posedge hclk) begin
    bus.haddr1     <= bus.haddr;
    bus.hwrite_reg <= bus.hwrite;
  end

  typedef struct packed {
    logic [2:0]  psel;
    logic        pen;
    logic        pwr;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        hrdy;
  } vec_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  vec_t  vq[$];
  xfer_t xq[$];
  int    errors = 0;
  int    checks = 0;

  vec_t  mon_e, mon_a;
  xfer_t mon_x;
  logic [31:0] mon_data;
  logic [2:0]  prev_sel = 3'b000;
  logic        prev_pen = 1'b0;

  localparam logic [31:0] Z   = 32'h0;
  localparam logic [31:0] A1R = 32'h8000_0010, R1 = 32'hDEAD_BEEF;
  localparam logic [31:0] AW  = 32'h8400_0004, DW = 32'h1234_5678;
  localparam logic [31:0] B1  = 32'h8400_0100, E1 = 32'hAAAA_0001;
  localparam logic [31:0] B2  = 32'h8400_0200, E2 = 32'hBBBB_0002;
  localparam logic [31:0] CW  = 32'h8800_0008, CD = 32'hCAFE_0003;
  localparam logic [31:0] CR  = 32'h8800_0020, CP = 32'h5555_AAAA;
  localparam logic [31:0] A5  = 32'h8000_0040, R5 = 32'h0BAD_F00D;
  localparam logic [31:0] A6  = 32'h8000_0080, R6 = 32'h1357_9BDF;
  localparam logic [31:0] A7  = 32'h9000_0000;
  localparam logic [31:0] A8  = 32'h8000_0100, R8 = 32'h1111_2222;
  localparam logic [31:0] A9  = 32'h8000_0200, R9 = 32'h3333_4444;

  function automatic vec_t ev(input logic [2:0] s, input logic pe, input logic pw,
                              input logic [31:0] pa, input logic [31:0] pd, input logic hr);
    ev = {s, pe, pw, pa, pd, hr};
  endfunction

  function automatic xfer_t ex(input logic wr, input logic [31:0] a, input logic [31:0] d);
    ex = {wr, a, d};
  endfunction

  // Drive one cycle of AHB inputs and queue the outputs expected after the coming rising edge.
  task automatic step(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] sel, input logic [31:0] rd, input vec_t e);
    bus.valid    = v;
    bus.hwrite   = w;
    bus.haddr    = a;
    bus.hwdata   = d;
    bus.temp_sel = sel;
    bus.prdata   = rd;
    vq.push_back(e);
    @(negedge hclk);
  endtask

  task automatic check_reset(input string name);
    mon_a = {bus.pselx, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.hready_out};
    checks++;
    if (mon_a !== ev(3'b000, 1'b0, 1'b0, Z, Z, 1'b1)) begin
      errors++;
      $display("FAIL %s: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h hrdy=%b, want psel=000 pen=0 pwr=0 paddr=0 pwdata=0 hrdy=1",
               name, mon_a.psel, mon_a.pen, mon_a.pwr, mon_a.paddr, mon_a.pwdata, mon_a.hrdy);
    end
  endtask

  // Monitor: per-cycle output vector check plus APB transfer scoreboard.
  always begin
    @(posedge hclk);
    #1;
    if (!hreset && vq.size() > 0) begin
      mon_e = vq.pop_front();
      mon_a = {bus.pselx, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.hready_out};
      checks++;
      if (mon_a !== mon_e || bus.hresp !== 2'b00) begin
        errors++;
        $display("FAIL cycle_vec t=%0t: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h hrdy=%b hresp=%b, want psel=%b pen=%b pwr=%b paddr=%h pwdata=%h hrdy=%b hresp=00",
                 $time, mon_a.psel, mon_a.pen, mon_a.pwr, mon_a.paddr, mon_a.pwdata, mon_a.hrdy, bus.hresp,
                 mon_e.psel, mon_e.pen, mon_e.pwr, mon_e.paddr, mon_e.pwdata, mon_e.hrdy);
      end
    end
    if (!hreset && bus.penable === 1'b1 && bus.pselx !== 3'b000) begin
      checks++;
      mon_data = bus.pwrite ? bus.pwdata : bus.hr_data;
      if (xq.size() == 0) begin
        errors++;
        $display("FAIL apb_xfer t=%0t: unexpected transfer wr=%b addr=%h data=%h, want none",
                 $time, bus.pwrite, bus.paddr, mon_data);
      end else begin
        mon_x = xq.pop_front();
        if (bus.pwrite !== mon_x.wr || bus.paddr !== mon_x.addr || mon_data !== mon_x.data ||
            prev_pen !== 1'b0 || prev_sel !== bus.pselx) begin
          errors++;
          $display("FAIL apb_xfer t=%0t: got wr=%b addr=%h data=%h setup(pen=%b sel=%b) sel=%b, want wr=%b addr=%h data=%h setup(pen=0 sel=%b)",
                   $time, bus.pwrite, bus.paddr, mon_data, prev_pen, prev_sel, bus.pselx,
                   mon_x.wr, mon_x.addr, mon_x.data, bus.pselx);
        end
      end
    end
    prev_sel = bus.pselx;
    prev_pen = bus.penable;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.valid = 1'b0; bus.hwrite = 1'b0; bus.haddr = Z; bus.hwdata = Z;
    bus.temp_sel = 3'b000; bus.prdata = Z;

    // Reset asserted between edges must take effect without a clock.
    #2 hreset = 1'b1;
    #1 check_reset("reset_async");
    repeat (2) @(negedge hclk);
    check_reset("reset_hold");
    hreset = 1'b0;

    // Single read.
    xq.push_back(ex(1'b0, A1R, R1));
    step(1'b1, 1'b0, A1R, Z, 3'b001, R1, ev(3'b001, 1'b0, 1'b0, A1R, Z, 1'b0));
    step(1'b0, 1'b0, A1R, Z, 3'b001, R1, ev(3'b001, 1'b1, 1'b0, A1R, Z, 1'b1));
    step(1'b0, 1'b0, A1R, Z, 3'b001, R1, ev(3'b000, 1'b0, 1'b0, A1R, Z, 1'b1));

    // Single write: WWAIT, WRITE, WENABLE, IDLE.
    xq.push_back(ex(1'b1, AW, DW));
    step(1'b1, 1'b1, AW, Z,  3'b010, Z, ev(3'b000, 1'b0, 1'b0, A1R, Z, 1'b1));
    step(1'b0, 1'b0, AW, DW, 3'b010, Z, ev(3'b010, 1'b0, 1'b1, AW, DW, 1'b1));
    step(1'b0, 1'b0, AW, DW, 3'b010, Z, ev(3'b010, 1'b1, 1'b1, AW, DW, 1'b1));
    step(1'b0, 1'b0, AW, DW, 3'b010, Z, ev(3'b000, 1'b0, 1'b1, AW, DW, 1'b1));

    // Back-to-back writes: WWAIT, WRITEP, WENABLEP, WRITE, WENABLE, IDLE.
    xq.push_back(ex(1'b1, B1, E1));
    xq.push_back(ex(1'b1, B2, E2));
    step(1'b1, 1'b1, B1, DW, 3'b010, Z, ev(3'b000, 1'b0, 1'b1, AW, DW, 1'b1));
    step(1'b1, 1'b1, B2, E1, 3'b010, Z, ev(3'b010, 1'b0, 1'b1, B1, E1, 1'b0));
    step(1'b0, 1'b1, B2, E2, 3'b010, Z, ev(3'b010, 1'b1, 1'b1, B1, E1, 1'b1));
    step(1'b0, 1'b0, B2, E2, 3'b010, Z, ev(3'b010, 1'b0, 1'b1, B2, E2, 1'b1));
    step(1'b0, 1'b0, B2, E2, 3'b010, Z, ev(3'b010, 1'b1, 1'b1, B2, E2, 1'b1));
    step(1'b0, 1'b0, B2, E2, 3'b010, Z, ev(3'b000, 1'b0, 1'b1, B2, E2, 1'b1));

    // Write immediately followed by a read: WENABLEP goes straight to READ.
    xq.push_back(ex(1'b1, CW, CD));
    xq.push_back(ex(1'b0, CR, CP));
    step(1'b1, 1'b1, CW, E2, 3'b100, CP, ev(3'b000, 1'b0, 1'b1, B2, E2, 1'b1));
    step(1'b1, 1'b0, CR, CD, 3'b100, CP, ev(3'b100, 1'b0, 1'b1, CW, CD, 1'b0));
    step(1'b0, 1'b0, CR, CD, 3'b100, CP, ev(3'b100, 1'b1, 1'b1, CW, CD, 1'b1));
    step(1'b0, 1'b0, CR, CD, 3'b100, CP, ev(3'b100, 1'b0, 1'b0, CR, CD, 1'b0));
    step(1'b0, 1'b0, CR, CD, 3'b100, CP, ev(3'b100, 1'b1, 1'b0, CR, CD, 1'b1));
    step(1'b0, 1'b0, CR, CD, 3'b100, CP, ev(3'b000, 1'b0, 1'b0, CR, CD, 1'b1));

    // Reset pulsed during RENABLE, then a fresh read.
    xq.push_back(ex(1'b0, A5, R5));
    step(1'b1, 1'b0, A5, CD, 3'b001, R5, ev(3'b001, 1'b0, 1'b0, A5, CD, 1'b0));
    step(1'b0, 1'b0, A5, CD, 3'b001, R5, ev(3'b001, 1'b1, 1'b0, A5, CD, 1'b1));
    hreset = 1'b1;
    #1 check_reset("reset_mid_xfer");
    #1 hreset = 1'b0;
    xq.push_back(ex(1'b0, A6, R6));
    step(1'b1, 1'b0, A6, Z, 3'b001, R6, ev(3'b001, 1'b0, 1'b0, A6, Z, 1'b0));
    step(1'b0, 1'b0, A6, Z, 3'b001, R6, ev(3'b001, 1'b1, 1'b0, A6, Z, 1'b1));
    step(1'b0, 1'b0, A6, Z, 3'b001, R6, ev(3'b000, 1'b0, 1'b0, A6, Z, 1'b1));

    // temp_sel of 000 passes through untouched.
    step(1'b1, 1'b0, A7, Z, 3'b000, R6, ev(3'b000, 1'b0, 1'b0, A7, Z, 1'b0));
    step(1'b0, 1'b0, A7, Z, 3'b000, R6, ev(3'b000, 1'b1, 1'b0, A7, Z, 1'b1));
    step(1'b0, 1'b0, A7, Z, 3'b000, R6, ev(3'b000, 1'b0, 1'b0, A7, Z, 1'b1));

    // Back-to-back reads: RENABLE goes straight to READ.
    xq.push_back(ex(1'b0, A8, R8));
    xq.push_back(ex(1'b0, A9, R9));
    step(1'b1, 1'b0, A8, Z, 3'b001, R8, ev(3'b001, 1'b0, 1'b0, A8, Z, 1'b0));
    step(1'b1, 1'b0, A9, Z, 3'b001, R8, ev(3'b001, 1'b1, 1'b0, A8, Z, 1'b1));
    step(1'b1, 1'b0, A9, Z, 3'b001, R9, ev(3'b001, 1'b0, 1'b0, A9, Z, 1'b0));
    step(1'b0, 1'b0, A9, Z, 3'b001, R9, ev(3'b001, 1'b1, 1'b0, A9, Z, 1'b1));
    step(1'b0, 1'b0, A9, Z, 3'b001, R9, ev(3'b000, 1'b0, 1'b0, A9, Z, 1'b1));

    for (int i = 0; i < 10 && vq.size() > 0; i++) @(negedge hclk);
    checks++;
    if (xq.size() != 0 || vq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d transfers and %0d cycle vectors left unchecked, want 0 and 0",
               xq.size(), vq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
